// File: rtl/dmem_access_unit.sv
// Data-memory initiator: CPU byte/half/word loads and stores onto a word-only DMEM, sub-word stores via read-modify-write.
// Optional MISALIGN_TRAP_EN: misaligned half/word requests complete immediately with misalign_err and no DMEM access.
module dmem_access_unit #(
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] MEM_BASE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        SYS_reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        misalign_err,
    output logic [31:0] DMEM_address,
    output logic [31:0] DMEM_data_in,
    output logic        DMEM_mem_write,
    output logic        DMEM_mem_read,
    input  logic [31:0] DMEM_data_out
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RMW_RD, S_WRITE, S_RESP} state_t;

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_widx;
    logic [1:0]        r_lane;
    logic [1:0]        r_size;
    logic              r_uns;
    logic              r_write;
    logic [31:0]       r_wdata;
    logic [31:0]       r_merged;
    logic [31:0]       r_rdata;

    logic              w_accept;
    logic              w_misalign;
    logic [31:0]       w_off;
    logic [ADDR_W-1:0] w_idx;

    // Sign/zero-extend the selected lane of a read word; size 1x means full word.
    function automatic logic [31:0] load_ext(input logic [31:0] d, input logic [1:0] lane,
                                             input logic [1:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = lane[1] ? d[31:16] : d[15:0];
        case (size)
            2'b00:   load_ext = uns ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   load_ext = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: load_ext = d;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] d, input logic [31:0] wd,
                                          input logic [1:0] lane, input logic [1:0] size);
        logic [31:0] m;
        m = d;
        if (size == 2'b00) begin
            case (lane)
                2'd0:    m[7:0]   = wd[7:0];
                2'd1:    m[15:8]  = wd[7:0];
                2'd2:    m[23:16] = wd[7:0];
                default: m[31:24] = wd[7:0];
            endcase
        end else if (lane[1]) begin
            m[31:16] = wd[15:0];
        end else begin
            m[15:0] = wd[15:0];
        end
        merge = m;
    endfunction

    assign w_off    = req_addr - MEM_BASE;
    assign w_idx    = ADDR_W'(w_off >> 2);
    assign w_accept = (r_state == S_IDLE) && req_valid;

`ifdef MISALIGN_TRAP_EN
    logic r_mis;
    assign w_misalign   = ((req_size == 2'b01) && req_addr[0]) ||
                          (req_size[1] && (req_addr[1:0] != 2'b00));
    assign misalign_err = resp_valid && r_mis;
    always_ff @(posedge clk or posedge SYS_reset) begin
        if (SYS_reset)     r_mis <= 1'b0;
        else if (w_accept) r_mis <= w_misalign;
    end
`else
    assign w_misalign   = 1'b0;
    assign misalign_err = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_misalign)      w_next = S_RESP;
                    else if (!req_write) w_next = S_LOAD;
                    else if (req_size[1]) w_next = S_WRITE;
                    else                 w_next = S_RMW_RD;
                end
            end
            S_LOAD:   w_next = S_RESP;
            S_RMW_RD: w_next = S_WRITE;
            S_WRITE:  w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            r_state  <= S_IDLE;
            r_widx   <= '0;
            r_lane   <= 2'b00;
            r_size   <= 2'b00;
            r_uns    <= 1'b0;
            r_write  <= 1'b0;
            r_wdata  <= 32'h0;
            r_merged <= 32'h0;
            r_rdata  <= 32'h0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_widx  <= w_idx;
                r_lane  <= req_addr[1:0];
                r_size  <= req_size;
                r_uns   <= req_unsigned;
                r_write <= req_write;
                r_wdata <= req_wdata;
                if (w_misalign) r_rdata <= 32'h0;
            end
            if (r_state == S_LOAD)   r_rdata  <= load_ext(DMEM_data_out, r_lane, r_size, r_uns);
            if (r_state == S_RMW_RD) r_merged <= merge(DMEM_data_out, r_wdata, r_lane, r_size);
            if (r_state == S_WRITE)  r_rdata  <= 32'h0;
        end
    end

    // DMEM side decodes from state and latched fields only.
    assign req_ready      = (r_state == S_IDLE);
    assign resp_valid     = (r_state == S_RESP);
    assign resp_rdata     = r_rdata;
    assign DMEM_address   = 32'(r_widx);
    assign DMEM_mem_read  = (r_state == S_LOAD) || (r_state == S_RMW_RD);
    assign DMEM_mem_write = (r_state == S_WRITE) && r_write;
    assign DMEM_data_in   = DMEM_mem_write ? (r_size[1] ? r_wdata : r_merged) : 32'h0;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: word-array DMEM, queue-based reference model, directed plus random traffic.
module tb_dmem_access_unit;

    localparam int          ADDR_W   = 8;
    localparam logic [31:0] MEM_BASE = 32'h0000_0000;
    localparam int          DEPTH    = 1 << ADDR_W;

    logic        clk = 1'b0;
    logic        SYS_reset = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic        req_ready, resp_valid, misalign_err;
    logic [31:0] resp_rdata, DMEM_address, DMEM_data_in, DMEM_data_out;
    logic        DMEM_mem_write, DMEM_mem_read;

    dmem_access_unit #(.ADDR_W(ADDR_W), .MEM_BASE(MEM_BASE)) dut (
        .clk(clk), .SYS_reset(SYS_reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .misalign_err(misalign_err), .DMEM_address(DMEM_address),
        .DMEM_data_in(DMEM_data_in), .DMEM_mem_write(DMEM_mem_write),
        .DMEM_mem_read(DMEM_mem_read), .DMEM_data_out(DMEM_data_out)
    );

    always #5 clk = ~clk;

    // Memory behind the unit: combinational read, write on the negedge of a write cycle.
    logic [31:0] dmem [DEPTH];
    logic [31:0] model_mem [DEPTH];
    assign DMEM_data_out = dmem[DMEM_address[ADDR_W-1:0]];
    always @(negedge clk) if (DMEM_mem_write) dmem[DMEM_address[ADDR_W-1:0]] <= DMEM_data_in;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, bad = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic        mis;
        int          nrd;
        int          nwr;
        int          idx;
    } exp_t;
    exp_t q[$];

    int          last_acc = 0;
    int          last_resp_cyc = 0;
    logic [31:0] last_rdata = 32'h0;
    logic        last_mis = 1'b0;
    int          rd_cnt = 0, wr_cnt = 0;

    // Reference: what a request must return and how it changes memory, from the access rules alone.
    task automatic model_req(input logic w, input logic [1:0] sz, input logic uns,
                             input logic [31:0] a, input logic [31:0] wd, input int acc);
        exp_t        e;
        int          k, lat;
        logic [31:0] old, v, mask;
        logic        trap;
        e.idx = int'(((a - MEM_BASE) >> 2) % DEPTH);
        k     = int'(a % 4);
        old   = model_mem[e.idx];
        trap  = 1'b0;
`ifdef MISALIGN_TRAP_EN
        trap = (sz == 2'b01 && (k % 2) == 1) || (sz >= 2'b10 && k != 0);
`endif
        e.rdata = 32'h0; e.mis = 1'b0; e.nrd = 0; e.nwr = 0;
        if (trap) begin
            lat = 1; e.mis = 1'b1;
        end else if (!w) begin
            lat = 2; e.nrd = 1;
            if (sz == 2'b00) begin
                v = (old >> (8 * k)) & 32'hFF;
                e.rdata = (!uns && v >= 32'h80) ? (v | 32'hFFFF_FF00) : v;
            end else if (sz == 2'b01) begin
                v = (old >> ((k >= 2) ? 16 : 0)) & 32'hFFFF;
                e.rdata = (!uns && v >= 32'h8000) ? (v | 32'hFFFF_0000) : v;
            end else begin
                e.rdata = old;
            end
        end else begin
            e.nwr = 1;
            if (sz >= 2'b10) begin
                lat = 2;
                model_mem[e.idx] = wd;
            end else begin
                lat = 3; e.nrd = 1;
                if (sz == 2'b00) begin
                    mask = 32'hFF << (8 * k);
                    model_mem[e.idx] = (old & ~mask) | ((wd & 32'hFF) << (8 * k));
                end else begin
                    mask = 32'hFFFF << ((k >= 2) ? 16 : 0);
                    model_mem[e.idx] = (old & ~mask) | ((wd & 32'hFFFF) << ((k >= 2) ? 16 : 0));
                end
            end
        end
        e.due = acc + lat - 1;
        q.push_back(e);
    endtask

    // Per-cycle compare against the head of the expectation queue.
    always @(negedge clk) begin
        if (SYS_reset) begin
            rd_cnt = 0; wr_cnt = 0;
        end else begin
            if (DMEM_mem_read && DMEM_mem_write) chk("rd_wr_overlap", 32'd1, 32'd0);
            if (!DMEM_mem_write && DMEM_data_in != 32'h0) chk("data_in_idle", DMEM_data_in, 32'h0);
            if (DMEM_mem_read)  rd_cnt++;
            if (DMEM_mem_write) wr_cnt++;
            if ((DMEM_mem_read || DMEM_mem_write) && q.size() > 0)
                chk("dmem_addr", DMEM_address, 32'(q[0].idx));
            if (resp_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    chk("resp_cycle", 32'(cyc), 32'(q[0].due));
                    chk("resp_rdata", resp_rdata, q[0].rdata);
                    chk("misalign_err", 32'(misalign_err), 32'(q[0].mis));
                    chk("read_strobes", 32'(rd_cnt), 32'(q[0].nrd));
                    chk("write_strobes", 32'(wr_cnt), 32'(q[0].nwr));
                    last_resp_cyc = cyc; last_rdata = resp_rdata; last_mis = misalign_err;
                    void'(q.pop_front());
                end
                rd_cnt = 0; wr_cnt = 0;
            end else if (q.size() > 0 && cyc > q[0].due) begin
                chk("resp_timeout", 32'(cyc), 32'(q[0].due));
                void'(q.pop_front());
                rd_cnt = 0; wr_cnt = 0;
            end
        end
    end

    // Present a request from a negedge, wait (bounded) for acceptance, return just after the accept edge.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'(n), 32'd0);
            req_valid = 1'b0;
        end else begin
            last_acc = cyc + 1;
            model_req(w, sz, uns, a, wd, last_acc);
            @(posedge clk);
            #1 req_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q.size() != 0 || !req_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("idle_timeout", 32'(q.size()), 32'd0);
    endtask

    initial begin
        int          a1, nmis;
        logic [31:0] snap;
        logic [31:0] a;
        logic [1:0]  sz;

        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_strobes", 32'({DMEM_mem_read, DMEM_mem_write}), 32'd0);
        chk("rst_addr", DMEM_address, 32'h0);
        chk("rst_data_in", DMEM_data_in, 32'h0);
        chk("rst_misalign", 32'(misalign_err), 32'd0);
        SYS_reset = 1'b0;

        for (int i = 0; i < DEPTH; i++) begin
            dmem[i] = $urandom;
            model_mem[i] = dmem[i];
        end
        dmem[4] = 32'h8899_AABB; model_mem[4] = 32'h8899_AABB;

        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0); wait_idle();
        chk("lw_0x10", last_rdata, 32'h8899_AABB);
        chk("lw_latency", 32'(last_resp_cyc - last_acc), 32'd1);
        do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0); wait_idle();
        chk("lb_0x13", last_rdata, 32'hFFFF_FF88);
        do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0); wait_idle();
        chk("lbu_0x13", last_rdata, 32'h0000_0088);
        do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0); wait_idle();
        chk("lh_0x12", last_rdata, 32'hFFFF_8899);
        do_req(1'b0, 2'b01, 1'b1, 32'h10, 32'h0); wait_idle();
        chk("lhu_0x10", last_rdata, 32'h0000_AABB);

        do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h1234_5678); wait_idle();
        chk("sb_latency", 32'(last_resp_cyc - last_acc), 32'd2);
        chk("sb_mem", dmem[4], 32'h8899_78BB);
        chk("sb_rdata", last_rdata, 32'h0);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0); wait_idle();
        chk("lw_after_sb", last_rdata, 32'h8899_78BB);

        // Store followed by a request presented while the unit is still busy.
        do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEAD_BEEF);
        a1 = last_acc;
        do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        chk("held_accept_spacing", 32'(last_acc - a1), 32'd3);
        wait_idle();
        chk("sw_mem8", dmem[8], 32'hDEAD_BEEF);
        chk("lw_after_sw", last_rdata, 32'hDEAD_BEEF);

        do_req(1'b0, 2'b10, 1'b0, 32'h12, 32'h0); wait_idle();
`ifdef MISALIGN_TRAP_EN
        chk("lw_misaligned_err", 32'(last_mis), 32'd1);
        chk("lw_misaligned_rdata", last_rdata, 32'h0);
        chk("lw_misaligned_lat", 32'(last_resp_cyc - last_acc), 32'd0);
`else
        chk("lw_misaligned_err", 32'(last_mis), 32'd0);
        chk("lw_misaligned_rdata", last_rdata, 32'h8899_78BB);
`endif

        // Reset while the read half of a read-modify-write is in progress.
        snap = dmem[5];
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_addr = 32'h15; req_wdata = 32'hA5;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rmw_read_active", 32'(DMEM_mem_read), 32'd1);
        SYS_reset = 1'b1;
        #1;
        chk("rst_mid_read", 32'(DMEM_mem_read), 32'd0);
        chk("rst_mid_write", 32'(DMEM_mem_write), 32'd0);
        chk("rst_mid_ready", 32'(req_ready), 32'd1);
        repeat (2) @(negedge clk);
        SYS_reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_mid_ready_after", 32'(req_ready), 32'd1);
        chk("rst_mid_mem", dmem[5], snap);

        // Random traffic, including addresses that wrap past the DMEM depth.
        for (int i = 0; i < 80; i++) begin
            sz = 2'($urandom_range(0, 3));
            a  = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3)) + 32'($urandom_range(0, 1) * DEPTH * 4);
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
            if ($urandom_range(0, 2) == 0) wait_idle();
        end
        wait_idle();

        nmis = 0;
        for (int i = 0; i < DEPTH; i++) if (dmem[i] !== model_mem[i]) nmis++;
        chk("final_mem", 32'(nmis), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d want=0", cyc);
        $fatal(1, "timeout");
    end

endmodule
